// File: rtl/irq_controller_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding
// and interrupt vector arithmetic.
package irq_controller_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_ACKED
  } irq_state_t;

  localparam int NIBBLE_W = 4;
  localparam int VECTOR_W = 13;

  // ROM vector of a source; the 13-bit sum wraps naturally.
  function automatic logic [VECTOR_W-1:0] calc_vector(
    input logic [VECTOR_W-1:0] base,
    input int unsigned         idx,
    input int unsigned         stride
  );
    logic [31:0] offset;
    offset = idx * stride;
    return base + offset[VECTOR_W-1:0];
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU data bus and microcode interrupt handshake seen by the interrupt controller.
// master = CPU/microcode side, slave = controller side.
interface irq_controller_if
  import irq_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
);

  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  bus_read_en;
  logic                  bus_write_en;
  logic [NIBBLE_W-1:0]   bus_write_data;
  logic                  bus_hit;
  logic [NIBBLE_W-1:0]   bus_read_data;
  logic                  int_enable;
  logic                  irq_req;
  logic [VECTOR_W-1:0]   irq_vector;
  logic                  irq_ack;
  logic                  irq_pending;

  modport master (
    output bus_addr, bus_read_en, bus_write_en, bus_write_data, int_enable, irq_ack,
    input  bus_hit, bus_read_data, irq_req, irq_vector, irq_pending
  );

  modport slave (
    input  bus_addr, bus_read_en, bus_write_en, bus_write_data, int_enable, irq_ack,
    output bus_hit, bus_read_data, irq_req, irq_vector, irq_pending
  );

endinterface

// File: rtl/irq_controller_source.sv
// One interrupt source: sticky factor flags cleared by a flag read, plus a
// software-written mask; pending when any unmasked flag is set.
module irq_controller_source #(
  parameter int FACTOR_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FACTOR_BITS-1:0] set_pulse,
  input  logic                   clear,
  input  logic                   mask_we,
  input  logic [FACTOR_BITS-1:0] mask_wdata,
  output logic [FACTOR_BITS-1:0] flag,
  output logic [FACTOR_BITS-1:0] mask,
  output logic                   pending
);

  logic [FACTOR_BITS-1:0] flag_reg;
  logic [FACTOR_BITS-1:0] flag_next;
  logic [FACTOR_BITS-1:0] mask_reg;

  // A set pulse coinciding with a read-clear must survive the clear.
  assign flag_next = (flag_reg & ~{FACTOR_BITS{clear}}) | set_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_reg <= '0;
      mask_reg <= '0;
    end else begin
      flag_reg <= flag_next;
      if (mask_we) begin
        mask_reg <= mask_wdata;
      end
    end
  end

  assign flag    = flag_reg;
  assign mask    = mask_reg;
  assign pending = |(flag_reg & mask_reg);

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller top: nibble register decode, registered read mux,
// fixed-priority arbitration and the request/ack handshake to microcode.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int                    NUM_SOURCES   = 6,
  parameter int                    FACTOR_BITS   = 4,
  parameter int                    ADDR_WIDTH    = 12,
  parameter logic [ADDR_WIDTH-1:0] FLAG_BASE     = 12'hF00,
  parameter logic [ADDR_WIDTH-1:0] MASK_BASE     = 12'hF10,
  parameter logic [VECTOR_W-1:0]   VECTOR_BASE   = 13'h0102,
  parameter int                    VECTOR_STRIDE = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_SOURCES*FACTOR_BITS-1:0] factor_set,
  irq_controller_if.slave                    bus
);

  localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  logic [ADDR_WIDTH-1:0]  flag_off;
  logic [ADDR_WIDTH-1:0]  mask_off;
  logic                   flag_hit;
  logic                   mask_hit;
  logic [IDX_W-1:0]       flag_idx;
  logic [IDX_W-1:0]       mask_idx;

  logic [FACTOR_BITS-1:0] flag_arr [NUM_SOURCES];
  logic [FACTOR_BITS-1:0] mask_arr [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] pending_vec;
  logic                   irq_pending;
  logic [IDX_W-1:0]       winner;

  logic [NIBBLE_W-1:0]    read_data_reg;
  logic [NIBBLE_W-1:0]    read_data_next;

  irq_state_t             state_reg;
  irq_state_t             state_next;
  logic                   irq_req_reg;
  logic                   irq_req_next;
  logic [VECTOR_W-1:0]    irq_vector_reg;
  logic [VECTOR_W-1:0]    irq_vector_next;

  // Unsigned offset compare covers both bounds of each register window.
  assign flag_off = bus.bus_addr - FLAG_BASE;
  assign mask_off = bus.bus_addr - MASK_BASE;
  assign flag_hit = flag_off < ADDR_WIDTH'(NUM_SOURCES);
  assign mask_hit = mask_off < ADDR_WIDTH'(NUM_SOURCES);
  assign flag_idx = flag_off[IDX_W-1:0];
  assign mask_idx = mask_off[IDX_W-1:0];

  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      irq_controller_source #(
        .FACTOR_BITS(FACTOR_BITS)
      ) u_src (
        .clk        (clk),
        .reset      (reset),
        .set_pulse  (factor_set[gi*FACTOR_BITS +: FACTOR_BITS]),
        .clear      (bus.bus_read_en && flag_hit && (flag_idx == IDX_W'(gi))),
        .mask_we    (bus.bus_write_en && mask_hit && (mask_idx == IDX_W'(gi))),
        .mask_wdata (bus.bus_write_data[FACTOR_BITS-1:0]),
        .flag       (flag_arr[gi]),
        .mask       (mask_arr[gi]),
        .pending    (pending_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    read_data_next = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (flag_hit && (flag_idx == IDX_W'(i))) begin
        read_data_next[FACTOR_BITS-1:0] = flag_arr[i];
      end else if (mask_hit && (mask_idx == IDX_W'(i))) begin
        read_data_next[FACTOR_BITS-1:0] = mask_arr[i];
      end
    end
  end

  // Ascending scan: the last pending index seen is the highest priority.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (pending_vec[i]) begin
        winner = IDX_W'(i);
      end
    end
  end

  assign irq_pending = |pending_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_reg <= '0;
    end else if (bus.bus_read_en) begin
      read_data_reg <= read_data_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IRQ_IDLE;
      irq_req_reg    <= 1'b0;
      irq_vector_reg <= '0;
    end else begin
      state_reg      <= state_next;
      irq_req_reg    <= irq_req_next;
      irq_vector_reg <= irq_vector_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    irq_req_next    = irq_req_reg;
    irq_vector_next = irq_vector_reg;
    case (state_reg)
      IRQ_IDLE: begin
        if (bus.int_enable && irq_pending) begin
          state_next      = IRQ_REQ;
          irq_req_next    = 1'b1;
          irq_vector_next = calc_vector(VECTOR_BASE, 32'(winner), VECTOR_STRIDE);
        end
      end
      IRQ_REQ: begin
        if (bus.irq_ack) begin
          state_next   = IRQ_ACKED;
          irq_req_next = 1'b0;
        end else if (!bus.int_enable || !irq_pending) begin
          state_next   = IRQ_IDLE;
          irq_req_next = 1'b0;
        end
      end
      IRQ_ACKED: begin
        // Wait for microcode to clear I so a new request needs a fresh enable.
        if (!bus.int_enable) begin
          state_next = IRQ_IDLE;
        end
      end
      default: begin
        state_next   = IRQ_IDLE;
        irq_req_next = 1'b0;
      end
    endcase
  end

  assign bus.bus_hit       = flag_hit || mask_hit;
  assign bus.bus_read_data = read_data_reg;
  assign bus.irq_req       = irq_req_reg;
  assign bus.irq_vector    = irq_vector_reg;
  assign bus.irq_pending   = irq_pending;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expected read data and vectors are queued
// by the stimulus and compared by a monitor when the DUT presents them.
module tb_irq_controller;
  import irq_controller_pkg::*;

  localparam int NS = 6;
  localparam int FB = 4;
  localparam int AW = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NS*FB-1:0]  factor_set = '0;

  irq_controller_if #(.ADDR_WIDTH(AW)) bus ();

  irq_controller #(
    .NUM_SOURCES  (NS),
    .FACTOR_BITS  (FB),
    .ADDR_WIDTH   (AW),
    .FLAG_BASE    (12'hF00),
    .MASK_BASE    (12'hF10),
    .VECTOR_BASE  (13'h0102),
    .VECTOR_STRIDE(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .factor_set(factor_set),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [3:0]  rd_q  [$];
  logic [12:0] irq_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: read data is presented the cycle after a read strobe;
  // a vector is presented on each rising irq_req.
  logic rd_d  = 1'b0;
  logic req_d = 1'b0;

  always @(posedge clk) rd_d <= bus.bus_read_en;

  always @(negedge clk) begin
    logic [3:0]  exp_rd;
    logic [12:0] exp_vec;
    if (rd_d) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %0h expected no read", bus.bus_read_data);
      end else begin
        exp_rd = rd_q.pop_front();
        $display("t=%0t read data=%0h exp=%0h", $time, bus.bus_read_data, exp_rd);
        check("rd_data", 32'(bus.bus_read_data), 32'(exp_rd));
      end
    end
    if (bus.irq_req && !req_d) begin
      if (irq_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL irq_unexpected: got vector %0h expected no request", bus.irq_vector);
      end else begin
        exp_vec = irq_q.pop_front();
        $display("t=%0t irq vector=%0h exp=%0h", $time, bus.irq_vector, exp_vec);
        check("irq_vector", 32'(bus.irq_vector), 32'(exp_vec));
      end
    end
    req_d <= bus.irq_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [3:0] d);
    bus.bus_addr       = a;
    bus.bus_write_data = d;
    bus.bus_write_en   = 1'b1;
    step();
    bus.bus_write_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input logic [3:0] exp);
    bus.bus_addr    = a;
    bus.bus_read_en = 1'b1;
    rd_q.push_back(exp);
    step();
    bus.bus_read_en = 1'b0;
  endtask

  task automatic pulse(input int bit_idx);
    factor_set[bit_idx] = 1'b1;
    step();
    factor_set = '0;
  endtask

  task automatic wait_req(input logic val, input int budget);
    int n;
    n = 0;
    while (bus.irq_req !== val && n < budget) begin
      step();
      n++;
    end
    check("wait_req", 32'(bus.irq_req), 32'(val));
  endtask

  task automatic hit_chk(input logic [AW-1:0] a, input logic exp);
    bus.bus_addr = a;
    #1;
    check("bus_hit", 32'(bus.bus_hit), 32'(exp));
  endtask

  initial begin
    bus.bus_addr       = '0;
    bus.bus_read_en    = 1'b0;
    bus.bus_write_en   = 1'b0;
    bus.bus_write_data = '0;
    bus.int_enable     = 1'b0;
    bus.irq_ack        = 1'b0;
    #2;
    check("rst_req", 32'(bus.irq_req), 0);
    check("rst_vec", 32'(bus.irq_vector), 0);
    check("rst_rdata", 32'(bus.bus_read_data), 0);
    check("rst_pend", 32'(bus.irq_pending), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    hit_chk(12'hF00, 1'b1);
    hit_chk(12'hF05, 1'b1);
    hit_chk(12'hF06, 1'b0);
    hit_chk(12'hF10, 1'b1);
    hit_chk(12'hF15, 1'b1);
    hit_chk(12'hF16, 1'b0);
    hit_chk(12'hEFF, 1'b0);

    // Test 1: source 2 flag 0, latency and vector
    bus_write(12'hF12, 4'h1);
    bus.int_enable = 1'b1;
    irq_q.push_back(13'h0106);
    pulse(8);
    check("t1_pend", 32'(bus.irq_pending), 1);
    check("t1_req_lat1", 32'(bus.irq_req), 0);
    step();
    check("t1_req_lat2", 32'(bus.irq_req), 1);
    check("t1_vec", 32'(bus.irq_vector), 32'h106);
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    check("t1_ack_drop", 32'(bus.irq_req), 0);
    repeat (3) step();
    check("t1_acked_hold", 32'(bus.irq_req), 0);
    bus.int_enable = 1'b0;
    step();

    // Test 3: read-clear racing a set pulse
    bus.bus_addr    = 12'hF02;
    bus.bus_read_en = 1'b1;
    factor_set[8]   = 1'b1;
    rd_q.push_back(4'h1);
    step();
    bus.bus_read_en = 1'b0;
    factor_set      = '0;
    bus_read(12'hF02, 4'h1);
    bus_read(12'hF02, 4'h0);
    check("t3_pend_clr", 32'(bus.irq_pending), 0);
    bus_read(12'hF12, 4'h1);
    bus_read(12'hF12, 4'h1);
    bus_read(12'h123, 4'h0);
    bus_write(12'hF03, 4'hF);

    // Test 2: priority between sources 1 and 4, vector latched during REQ
    bus_write(12'hF11, 4'hF);
    bus_write(12'hF14, 4'hF);
    factor_set[4]  = 1'b1;
    factor_set[16] = 1'b1;
    step();
    factor_set = '0;
    check("t2_pend_noen", 32'(bus.irq_pending), 1);
    check("t2_req_noen", 32'(bus.irq_req), 0);
    irq_q.push_back(13'h010A);
    bus.int_enable = 1'b1;
    step();
    check("t2_req", 32'(bus.irq_req), 1);
    bus_write(12'hF15, 4'hF);
    pulse(20);
    step();
    check("t2_vec_hold", 32'(bus.irq_vector), 32'h10A);
    bus.irq_ack = 1'b1;
    step();
    check("t2_ack_drop", 32'(bus.irq_req), 0);
    step();
    bus.irq_ack = 1'b0;
    step();
    check("t2_ack_ignored", 32'(bus.irq_req), 0);
    bus.int_enable = 1'b0;
    step();
    bus_read(12'hF01, 4'h1);
    bus_read(12'hF04, 4'h1);
    bus_read(12'hF05, 4'h1);
    bus_read(12'hF03, 4'h0);
    check("t2_pend_clr", 32'(bus.irq_pending), 0);

    // Test 4: read-clear of the only pending source withdraws the request
    bus.int_enable = 1'b1;
    irq_q.push_back(13'h0106);
    pulse(8);
    wait_req(1'b1, 5);
    bus_read(12'hF02, 4'h1);
    check("t4_pend", 32'(bus.irq_pending), 0);
    check("t4_req_still", 32'(bus.irq_req), 1);
    step();
    check("t4_withdraw", 32'(bus.irq_req), 0);
    repeat (2) step();
    check("t4_stay_idle", 32'(bus.irq_req), 0);

    // Test 5: masked-off flags, then enabling the mask
    factor_set[12] = 1'b1;
    factor_set[13] = 1'b1;
    step();
    factor_set = '0;
    check("t5_pend_masked", 32'(bus.irq_pending), 0);
    step();
    check("t5_req_masked", 32'(bus.irq_req), 0);
    irq_q.push_back(13'h0108);
    bus_write(12'hF13, 4'h2);
    check("t5_pend_after_wr", 32'(bus.irq_pending), 1);
    check("t5_req_after_wr", 32'(bus.irq_req), 0);
    step();
    check("t5_req", 32'(bus.irq_req), 1);
    bus.bus_addr       = 12'hF13;
    bus.bus_write_data = 4'h5;
    bus.bus_write_en   = 1'b1;
    bus.bus_read_en    = 1'b1;
    rd_q.push_back(4'h2);
    step();
    bus.bus_write_en = 1'b0;
    bus.bus_read_en  = 1'b0;
    bus_read(12'hF13, 4'h5);
    check("t5_req_keep", 32'(bus.irq_req), 1);

    // Test 6: asynchronous reset while requesting
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t6_req", 32'(bus.irq_req), 0);
    check("t6_vec", 32'(bus.irq_vector), 0);
    check("t6_rdata", 32'(bus.bus_read_data), 0);
    check("t6_pend", 32'(bus.irq_pending), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_read(12'hF13, 4'h0);
    bus_read(12'hF03, 4'h0);
    repeat (2) step();

    check("rd_q_empty", 32'(rd_q.size()), 0);
    check("irq_q_empty", 32'(irq_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1);
  end

endmodule
